// File: rtl/cnn_seq_pkg.sv
// Shared definitions for the layer sequencer: state and layer-kind encodings, per-layer base table.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package cnn_seq_pkg;

    localparam int SRAM_ADDR_BITS = 16;
    localparam int NUM_LAYERS     = 7;
    localparam int W_BITS         = 17;
    localparam int B_BITS         = 8;
    localparam int ID_BITS        = 3;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ISSUE  = 2'd1,
        ST_WAIT   = 2'd2,
        ST_FINISH = 2'd3
    } seq_state_e;

    typedef enum logic [1:0] {
        KIND_CONV   = 2'd0,
        KIND_POOL   = 2'd1,
        KIND_FC     = 2'd2,
        KIND_ARGMAX = 2'd3
    } layer_kind_e;

    typedef struct packed {
        layer_kind_e                kind;
        logic [W_BITS-1:0]          w_base;
        logic [B_BITS-1:0]          b_base;
        logic [SRAM_ADDR_BITS-1:0]  src_base;
        logic [SRAM_ADDR_BITS-1:0]  dst_base;
    } layer_cfg_t;

    // Unused fields are zero. Layer 0 reads the image ROM, so its src is meaningless.
    // Activations ping-pong between SRAM offsets 0 and 4704.
    localparam layer_cfg_t LAYER_TABLE [NUM_LAYERS] = '{
        '{KIND_CONV,   17'd0,     8'd0,   16'd0,    16'd0},
        '{KIND_POOL,   17'd0,     8'd0,   16'd0,    16'd4704},
        '{KIND_CONV,   17'd54,    8'd6,   16'd4704, 16'd0},
        '{KIND_POOL,   17'd0,     8'd0,   16'd0,    16'd4704},
        '{KIND_FC,     17'd864,   8'd21,  16'd4704, 16'd0},
        '{KIND_FC,     17'd98064, 8'd201, 16'd0,    16'd4704},
        '{KIND_ARGMAX, 17'd0,     8'd0,   16'd4704, 16'd0}
    };

    // A stop request beyond the last layer means "run everything".
    function automatic logic [ID_BITS-1:0] clamp_stop(input logic [ID_BITS-1:0] s);
        logic [ID_BITS-1:0] last;
        last = ID_BITS'(NUM_LAYERS - 1);
        return (s > last) ? last : s;
    endfunction

endpackage

// File: rtl/layer_sequencer_if.sv
// Control bundle between the run controller, the sequencer and the layer engines.
// Latency: n/a (wires only).
// Backpressure: none; START and layer_done are single-cycle pulses.
interface layer_sequencer_if
    import cnn_seq_pkg::*;
#(
    parameter int SA_BITS = SRAM_ADDR_BITS
);
    logic                   START;
    logic [ID_BITS-1:0]     stop_layer;
    logic                   layer_done;
    logic                   layer_start;
    logic [ID_BITS-1:0]     layer_id;
    logic [1:0]             layer_kind;
    logic [W_BITS-1:0]      w_base;
    logic [B_BITS-1:0]      b_base;
    logic [SA_BITS-1:0]     src_base;
    logic [SA_BITS-1:0]     dst_base;
    logic                   DONE;
    logic                   err;

    // Sequencer side.
    modport master (
        input  START, stop_layer, layer_done,
        output layer_start, layer_id, layer_kind, w_base, b_base,
               src_base, dst_base, DONE, err
    );

    // Controller / engine side.
    modport slave (
        output START, stop_layer, layer_done,
        input  layer_start, layer_id, layer_kind, w_base, b_base,
               src_base, dst_base, DONE, err
    );
endinterface

// File: rtl/layer_cfg_lut.sv
// Combinational decode of a layer index into its kind and ROM/SRAM base addresses.
// Latency: 0 cycles (pure combinational).
// Backpressure: none.
module layer_cfg_lut
    import cnn_seq_pkg::*;
#(
    parameter int SA_BITS = SRAM_ADDR_BITS
) (
    input  logic [ID_BITS-1:0]  layer_id,
    output layer_kind_e         kind,
    output logic [W_BITS-1:0]   w_base,
    output logic [B_BITS-1:0]   b_base,
    output logic [SA_BITS-1:0]  src_base,
    output logic [SA_BITS-1:0]  dst_base
);

    layer_cfg_t cfg;

    // Table lookup; the unused index 7 decodes to all zeros.
    always_comb begin
        cfg = '0;
        if (int'(layer_id) < NUM_LAYERS) begin
            cfg = LAYER_TABLE[layer_id];
        end
        kind     = cfg.kind;
        w_base   = cfg.w_base;
        b_base   = cfg.b_base;
        src_base = SA_BITS'(cfg.src_base);
        dst_base = SA_BITS'(cfg.dst_base);
    end

endmodule

// File: rtl/layer_sequencer.sv
// Steps the engines through layers 0..stop, kicking each and waiting for its done pulse, with a watchdog.
// Latency: layer_start 1 cycle after START or the previous layer_done; DONE 1 cycle after the final layer_done.
// Backpressure: START ignored while a run is active; layer_done ignored outside WAIT.
module layer_sequencer
    import cnn_seq_pkg::*;
#(
    parameter int TIMEOUT = 1000000,
    parameter int SA_BITS = SRAM_ADDR_BITS
) (
    input  logic                clk,
    input  logic                rst,
    layer_sequencer_if.master   bus
);

    localparam int               CNT_W    = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    seq_state_e          state_q, state_d;
    logic [ID_BITS-1:0]  layer_id_q, layer_id_d;
    logic [ID_BITS-1:0]  stop_q, stop_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic                start_q, start_d;
    logic                done_q, done_d;
    logic                err_q, err_d;
    layer_kind_e         kind_q, kind_d;
    logic [W_BITS-1:0]   w_base_q, w_base_d;
    logic [B_BITS-1:0]   b_base_q, b_base_d;
    logic [SA_BITS-1:0]  src_base_q, src_base_d;
    logic [SA_BITS-1:0]  dst_base_q, dst_base_d;

    // Decode the next layer index so the registered bases line up with layer_id itself.
    layer_cfg_lut #(.SA_BITS(SA_BITS)) u_lut (
        .layer_id (layer_id_d),
        .kind     (kind_d),
        .w_base   (w_base_d),
        .b_base   (b_base_d),
        .src_base (src_base_d),
        .dst_base (dst_base_d)
    );

    // Next-state logic: run control, watchdog and registered output values.
    always_comb begin
        state_d    = state_q;
        layer_id_d = layer_id_q;
        stop_d     = stop_q;
        cnt_d      = cnt_q;
        done_d     = done_q;
        err_d      = err_q;
        start_d    = 1'b0;
        case (state_q)
            ST_IDLE, ST_FINISH: begin
                if (bus.START) begin
                    state_d    = ST_ISSUE;
                    layer_id_d = '0;
                    stop_d     = clamp_stop(bus.stop_layer);
                    done_d     = 1'b0;
                    err_d      = 1'b0;
                    start_d    = 1'b1;
                end
            end
            ST_ISSUE: begin
                state_d = ST_WAIT;
                cnt_d   = '0;
            end
            ST_WAIT: begin
                // A done pulse on the watchdog's last cycle still counts as success.
                if (bus.layer_done) begin
                    if (layer_id_q == stop_q) begin
                        state_d = ST_FINISH;
                        done_d  = 1'b1;
                    end else begin
                        state_d    = ST_ISSUE;
                        layer_id_d = layer_id_q + 1'b1;
                        start_d    = 1'b1;
                    end
                end else if (cnt_q == CNT_LAST) begin
                    state_d = ST_FINISH;
                    done_d  = 1'b1;
                    err_d   = 1'b1;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // State and registered outputs; reset abandons any run in progress.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= ST_IDLE;
            layer_id_q <= '0;
            stop_q     <= '0;
            cnt_q      <= '0;
            start_q    <= 1'b0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
            kind_q     <= KIND_CONV;
            w_base_q   <= '0;
            b_base_q   <= '0;
            src_base_q <= '0;
            dst_base_q <= '0;
        end else begin
            state_q    <= state_d;
            layer_id_q <= layer_id_d;
            stop_q     <= stop_d;
            cnt_q      <= cnt_d;
            start_q    <= start_d;
            done_q     <= done_d;
            err_q      <= err_d;
            kind_q     <= kind_d;
            w_base_q   <= w_base_d;
            b_base_q   <= b_base_d;
            src_base_q <= src_base_d;
            dst_base_q <= dst_base_d;
        end
    end

    assign bus.layer_start = start_q;
    assign bus.layer_id    = layer_id_q;
    assign bus.layer_kind  = kind_q;
    assign bus.w_base      = w_base_q;
    assign bus.b_base      = b_base_q;
    assign bus.src_base    = src_base_q;
    assign bus.dst_base    = dst_base_q;
    assign bus.DONE        = done_q;
    assign bus.err         = err_q;

endmodule
